sdram_arbiter2: RTL and testbench
=================================

SDRAM_ARBITER2 -- requirements
Module: sdram_arbiter2

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, regardless of clock.
REQ-003 SHALL have ports, per client N in {0,1}: in_sdN_addr  input  32  request address.
REQ-004 SHALL have ports: in_sdN_rw  input  1  1=read, 0=write.
REQ-005 SHALL have ports: in_sdN_data_in  input  32  write data.
REQ-006 SHALL have ports: in_sdN_wmask  input  1  write mask, passed through unchanged.
REQ-007 SHALL have ports: in_sdN_in_valid  input  1  one-cycle request pulse.
REQ-008 SHALL have ports: out_sdN_data_out  output  32  read data for client N.
REQ-009 SHALL have ports: out_sdN_done  output  1  one-cycle completion pulse to client N.
REQ-010 SHALL have ports: out_sd_addr 32, out_sd_rw 1, out_sd_data_in 32, out_sd_wmask 1, out_sd_in_valid 1  output  downstream SDRAM controller request.
REQ-011 SHALL have ports: in_sd_data_out  input  32  downstream read data; in_sd_done  input  1  downstream completion pulse.
REQ-012 SHALL have ports: out_grant  output  1  client owning current/last transaction; out_busy  output  1  transaction in flight; out_overrun  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL latch each client pulse into a per-client pending slot (addr, rw, data, wmask) on the edge sampling in_sdN_in_valid=1.
REQ-014 SHALL, on in_sdN_in_valid=1 while slot N already pending, discard the new request, keep the old slot intact, and set out_overrun=1 until reset.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT; reset state IDLE.
REQ-016 IDLE: if any slot pending, SHALL select a client, load out_sd_addr/rw/data_in/wmask from its slot, set out_grant, go ISSUE; else stay IDLE.
REQ-017 Selection SHALL be round-robin: one pending -> that client; both pending -> client != last granted client.
REQ-018 ISSUE SHALL last exactly one cycle with out_sd_in_valid=1, then go WAIT; out_sd_in_valid SHALL be 0 in every other cycle.
REQ-019 out_sd_addr/rw/data_in/wmask SHALL hold stable from ISSUE through end of WAIT.
REQ-020 WAIT: on in_sd_done=1, SHALL register in_sd_data_out into out_sdG_data_out (G=granted), pulse out_sdG_done=1 for exactly the next cycle, clear slot G, record G as last granted, return IDLE.
REQ-021 in_sd_done SHALL be ignored in IDLE and ISSUE.
REQ-022 out_sdN_data_out SHALL hold its value until client N's next completion; written on reads and writes alike.
REQ-023 Latency: request pulse in cycle t -> out_sd_in_valid=1 in cycle t+2 when idle and uncontended; in_sd_done in cycle k -> out_sdG_done=1 in cycle k+1; next grant's out_sd_in_valid no earlier than k+2.
REQ-024 A request arriving in the cycle its own slot is being cleared (done sampled) SHALL count as overrun per REQ-014.
REQ-025 out_busy SHALL be 1 in ISSUE and WAIT, 0 in IDLE.
REQ-026 Simultaneous pulses from both clients SHALL both be latched; served in round-robin order.

Reset
REQ-027 On reset=0: state IDLE, slots cleared, last granted=1 (client 0 wins first tie), out_sd_addr=0, out_sd_rw=1, out_sd_data_in=0, out_sd_wmask=0, out_sd_in_valid=0, out_sdN_data_out=0, out_sdN_done=0, out_grant=0, out_busy=0, out_overrun=0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no done pulse to any client; in_sd_done arriving after release SHALL be ignored (IDLE).

Verification
REQ-029 Single write: client1 pulse addr=0x0100_0005, rw=0, data=0xFF -> out_sd_in_valid=1 two cycles later with same fields; in_sd_done 3 cycles later -> out_sd1_done=1 next cycle, out_sd0_done=0.
REQ-030 Read return: client0 read addr=0x10, in_sd_data_out=0xDEADBEEF with in_sd_done -> out_sd0_data_out=0xDEADBEEF and out_sd0_done=1 same cycle; value held afterwards.
REQ-031 Contention: both pulse same cycle after reset -> client0 issued first, client1 issued no earlier than 2 cycles after client0 done; repeat both -> order alternates 0,1,0,1.
REQ-032 Overrun: client1 pulses twice before done (addrs 0x20, 0x24) -> only 0x20 issued, out_overrun=1 and stays 1.
REQ-033 Reset mid-WAIT: assert reset=0 between ISSUE and in_sd_done -> all outputs at REQ-027 values immediately (no clock edge needed); later in_sd_done -> no done pulse.
REQ-034 Spurious done: in_sd_done=1 while IDLE -> no out_sdN_done, state unchanged.

Source files
------------

// File: rtl/sdram_arbiter2_if.sv
// sdram_arbiter2_if: client request/response signals plus the downstream SDRAM controller port
interface sdram_arbiter2_if;
    logic [31:0] in_sd0_addr, in_sd1_addr;
    logic        in_sd0_rw, in_sd1_rw;
    logic [31:0] in_sd0_data_in, in_sd1_data_in;
    logic        in_sd0_wmask, in_sd1_wmask;
    logic        in_sd0_in_valid, in_sd1_in_valid;
    logic [31:0] out_sd0_data_out, out_sd1_data_out;
    logic        out_sd0_done, out_sd1_done;
    logic [31:0] out_sd_addr;
    logic        out_sd_rw;
    logic [31:0] out_sd_data_in;
    logic        out_sd_wmask;
    logic        out_sd_in_valid;
    logic [31:0] in_sd_data_out;
    logic        in_sd_done;
    logic        out_grant, out_busy, out_overrun;

    modport slave (
        input  in_sd0_addr, in_sd0_rw, in_sd0_data_in, in_sd0_wmask, in_sd0_in_valid,
               in_sd1_addr, in_sd1_rw, in_sd1_data_in, in_sd1_wmask, in_sd1_in_valid,
               in_sd_data_out, in_sd_done,
        output out_sd0_data_out, out_sd0_done, out_sd1_data_out, out_sd1_done,
               out_sd_addr, out_sd_rw, out_sd_data_in, out_sd_wmask, out_sd_in_valid,
               out_grant, out_busy, out_overrun
    );

    modport master (
        output in_sd0_addr, in_sd0_rw, in_sd0_data_in, in_sd0_wmask, in_sd0_in_valid,
               in_sd1_addr, in_sd1_rw, in_sd1_data_in, in_sd1_wmask, in_sd1_in_valid,
               in_sd_data_out, in_sd_done,
        input  out_sd0_data_out, out_sd0_done, out_sd1_data_out, out_sd1_done,
               out_sd_addr, out_sd_rw, out_sd_data_in, out_sd_wmask, out_sd_in_valid,
               out_grant, out_busy, out_overrun
    );
endinterface

// File: rtl/sdram_arbiter2.sv
// sdram_arbiter2: two-client round-robin arbiter in front of a single SDRAM controller
module sdram_arbiter2 (
    input logic            clock,
    input logic            reset,
    sdram_arbiter2_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      state, state_nx;
    logic [1:0]  req_v, req_rw, req_wmask, pend, slot_rw, slot_wmask, done;
    logic [31:0] req_addr [2];
    logic [31:0] req_data [2];
    logic [31:0] slot_addr [2];
    logic [31:0] slot_data [2];
    logic [31:0] data_out [2];
    logic        last, grant, sel, fin, overrun, sd_rw, sd_wmask;
    logic [31:0] sd_addr, sd_data;

    assign req_v       = {bus.in_sd1_in_valid, bus.in_sd0_in_valid};
    assign req_rw      = {bus.in_sd1_rw, bus.in_sd0_rw};
    assign req_wmask   = {bus.in_sd1_wmask, bus.in_sd0_wmask};
    assign req_addr[0] = bus.in_sd0_addr;
    assign req_addr[1] = bus.in_sd1_addr;
    assign req_data[0] = bus.in_sd0_data_in;
    assign req_data[1] = bus.in_sd1_data_in;
    assign sel = &pend ? ~last : pend[1];
    assign fin = state == WAIT && bus.in_sd_done;

    // state register
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // next state: one issue cycle, then wait for the controller's done
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |pend ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = bus.in_sd_done ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // pending slots: latch fresh pulses, flag pulses hitting a full slot, free the slot on completion
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            pend       <= '0;
            slot_rw    <= '0;
            slot_wmask <= '0;
            slot_addr  <= '{default: '0};
            slot_data  <= '{default: '0};
            overrun    <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (req_v[n] && pend[n]) overrun <= 1'b1;
                else if (req_v[n]) begin
                    pend[n]       <= 1'b1;
                    slot_addr[n]  <= req_addr[n];
                    slot_data[n]  <= req_data[n];
                    slot_rw[n]    <= req_rw[n];
                    slot_wmask[n] <= req_wmask[n];
                end
                if (fin && grant == n[0]) pend[n] <= 1'b0;
            end
        end

    // downstream request fields are loaded at grant and held; completion returns data and pulses done
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            grant    <= 1'b0;
            last     <= 1'b1;
            sd_addr  <= '0;
            sd_rw    <= 1'b1;
            sd_data  <= '0;
            sd_wmask <= 1'b0;
            done     <= '0;
            data_out <= '{default: '0};
        end else begin
            done <= '0;
            if (state == IDLE && |pend) begin
                grant    <= sel;
                sd_addr  <= slot_addr[sel];
                sd_rw    <= slot_rw[sel];
                sd_data  <= slot_data[sel];
                sd_wmask <= slot_wmask[sel];
            end
            if (fin) begin
                data_out[grant] <= bus.in_sd_data_out;
                done[grant]     <= 1'b1;
                last            <= grant;
            end
        end

    assign bus.out_sd_addr      = sd_addr;
    assign bus.out_sd_rw        = sd_rw;
    assign bus.out_sd_data_in   = sd_data;
    assign bus.out_sd_wmask     = sd_wmask;
    assign bus.out_sd_in_valid  = state == ISSUE;
    assign bus.out_sd0_data_out = data_out[0];
    assign bus.out_sd1_data_out = data_out[1];
    assign bus.out_sd0_done     = done[0];
    assign bus.out_sd1_done     = done[1];
    assign bus.out_grant        = grant;
    assign bus.out_busy         = state != IDLE;
    assign bus.out_overrun      = overrun;
endmodule

// File: tb/tb_sdram_arbiter2.sv
// tb_sdram_arbiter2: directed scenarios plus a randomized run against a transaction-level model
module tb_sdram_arbiter2;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    localparam logic [135:0] RST_OUTS = {32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    sdram_arbiter2_if bus ();
    sdram_arbiter2 dut (.clock(clock), .reset(reset), .bus(bus));

    // free-running clock
    always #5 clock = ~clock;

    // cycle index for latency checks
    always @(posedge clock) cyc <= cyc + 1;

    // safety net against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [135:0] snap();
        return {bus.out_sd_addr, bus.out_sd_rw, bus.out_sd_data_in, bus.out_sd_wmask, bus.out_sd_in_valid,
                bus.out_sd0_data_out, bus.out_sd1_data_out, bus.out_sd0_done, bus.out_sd1_done,
                bus.out_grant, bus.out_busy, bus.out_overrun};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic quiet;
        bus.in_sd0_in_valid = 1'b0;
        bus.in_sd1_in_valid = 1'b0;
        bus.in_sd_done      = 1'b0;
    endtask

    task automatic pulse(input int n, input logic [31:0] a, input logic rw, input logic [31:0] d, input logic wm);
        if (n == 0) begin
            bus.in_sd0_addr = a; bus.in_sd0_rw = rw; bus.in_sd0_data_in = d; bus.in_sd0_wmask = wm; bus.in_sd0_in_valid = 1'b1;
        end else begin
            bus.in_sd1_addr = a; bus.in_sd1_rw = rw; bus.in_sd1_data_in = d; bus.in_sd1_wmask = wm; bus.in_sd1_in_valid = 1'b1;
        end
    endtask

    task automatic do_reset;
        quiet;
        reset = 1'b0;
        #3;
        @(negedge clock);
        reset = 1'b1;
        step;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (snap() !== RST_OUTS) begin fails++; $display("FAIL reset_hold: outputs=%h expected %h", snap(), RST_OUTS); end
        @(negedge clock);
        reset = 1'b1;
        step(2);
        checks++;
        if (snap() !== RST_OUTS) begin fails++; $display("FAIL reset_idle: outputs=%h expected %h", snap(), RST_OUTS); end
    endtask

    task automatic test_single_write;
        pulse(1, 32'h0100_0005, 1'b0, 32'hFF, 1'b0);
        step;
        quiet;
        checks++;
        if (bus.out_sd_in_valid !== 1'b0) begin fails++; $display("FAIL wr_early: in_valid=%b expected 0", bus.out_sd_in_valid); end
        step;
        checks++;
        if ({bus.out_sd_in_valid, bus.out_grant, bus.out_busy, bus.out_sd_addr, bus.out_sd_rw, bus.out_sd_data_in, bus.out_sd_wmask} !==
            {1'b1, 1'b1, 1'b1, 32'h0100_0005, 1'b0, 32'hFF, 1'b0}) begin
            fails++; $display("FAIL wr_issue: valid=%b grant=%b addr=%h rw=%b data=%h expected 1 1 01000005 0 000000ff",
                bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_sd_rw, bus.out_sd_data_in);
        end
        step;
        checks++;
        if ({bus.out_sd_in_valid, bus.out_busy} !== 2'b01) begin fails++; $display("FAIL wr_wait: valid/busy=%b expected 01", {bus.out_sd_in_valid, bus.out_busy}); end
        step(2);
        bus.in_sd_done = 1'b1;
        bus.in_sd_data_out = 32'h1234;
        step;
        quiet;
        checks++;
        if ({bus.out_sd1_done, bus.out_sd0_done, bus.out_busy, bus.out_sd1_data_out} !== {1'b1, 1'b0, 1'b0, 32'h1234}) begin
            fails++; $display("FAIL wr_done: done1=%b done0=%b busy=%b data1=%h expected 1 0 0 00001234",
                bus.out_sd1_done, bus.out_sd0_done, bus.out_busy, bus.out_sd1_data_out);
        end
        step;
        checks++;
        if (bus.out_sd1_done !== 1'b0) begin fails++; $display("FAIL wr_done_pulse: done1=%b expected 0", bus.out_sd1_done); end
    endtask

    task automatic test_read_return;
        pulse(0, 32'h10, 1'b1, 32'h0, 1'b0);
        step;
        quiet;
        step;
        checks++;
        if ({bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_sd_rw} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
            fails++; $display("FAIL rd_issue: valid=%b grant=%b addr=%h rw=%b expected 1 0 00000010 1",
                bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_sd_rw);
        end
        step;
        bus.in_sd_done = 1'b1;
        bus.in_sd_data_out = 32'hDEADBEEF;
        step;
        quiet;
        bus.in_sd_data_out = 32'h5555_AAAA;
        checks++;
        if ({bus.out_sd0_done, bus.out_sd0_data_out} !== {1'b1, 32'hDEADBEEF}) begin
            fails++; $display("FAIL rd_return: done0=%b data0=%h expected 1 deadbeef", bus.out_sd0_done, bus.out_sd0_data_out);
        end
        step(3);
        checks++;
        if ({bus.out_sd0_done, bus.out_sd0_data_out} !== {1'b0, 32'hDEADBEEF}) begin
            fails++; $display("FAIL rd_hold: done0=%b data0=%h expected 0 deadbeef", bus.out_sd0_done, bus.out_sd0_data_out);
        end
    endtask

    task automatic test_reset_mid_wait;
        pulse(1, 32'h30, 1'b0, 32'h77, 1'b1);
        step;
        pulse(1, 32'h34, 1'b0, 32'h78, 1'b1);
        step;
        quiet;
        step;
        checks++;
        if ({bus.out_busy, bus.out_overrun, bus.out_grant} !== 3'b111) begin
            fails++; $display("FAIL mid_pre: busy/overrun/grant=%b expected 111", {bus.out_busy, bus.out_overrun, bus.out_grant});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (snap() !== RST_OUTS) begin fails++; $display("FAIL mid_async_reset: outputs=%h expected %h", snap(), RST_OUTS); end
        @(negedge clock);
        reset = 1'b1;
        step;
        bus.in_sd_done = 1'b1;
        bus.in_sd_data_out = 32'h9999;
        step;
        quiet;
        checks++;
        if ({bus.out_sd0_done, bus.out_sd1_done, bus.out_busy, bus.out_sd1_data_out} !== {3'b000, 32'h0}) begin
            fails++; $display("FAIL mid_late_done: done0=%b done1=%b busy=%b data1=%h expected 0 0 0 0",
                bus.out_sd0_done, bus.out_sd1_done, bus.out_busy, bus.out_sd1_data_out);
        end
        step;
        checks++;
        if (bus.out_sd_in_valid !== 1'b0) begin fails++; $display("FAIL mid_no_reissue: in_valid=%b expected 0", bus.out_sd_in_valid); end
    endtask

    task automatic test_contention;
        do_reset;
        for (int r = 0; r < 2; r++) begin
            int k = -100;
            pulse(0, 32'h100 + r * 16, 1'b1, 32'h0, 1'b0);
            pulse(1, 32'h200 + r * 16, 1'b1, 32'h0, 1'b0);
            step;
            quiet;
            for (int i = 0; i < 2; i++) begin
                int w = 0;
                while (!bus.out_sd_in_valid && w < 10) begin step; w++; end
                checks++;
                if (bus.out_sd_in_valid !== 1'b1 || bus.out_grant !== i[0] || (i == 0 && w != 1) ||
                    bus.out_sd_addr !== (i == 0 ? 32'h100 : 32'h200) + r * 16) begin
                    fails++; $display("FAIL cont_order r=%0d i=%0d: valid=%b grant=%b addr=%h wait=%0d expected 1 %0d %h",
                        r, i, bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, w, i, (i == 0 ? 32'h100 : 32'h200) + r * 16);
                end
                checks++;
                if (cyc < k + 2) begin fails++; $display("FAIL cont_gap r=%0d: issue cycle %0d, required >= %0d", r, cyc, k + 2); end
                step(2);
                bus.in_sd_done = 1'b1;
                bus.in_sd_data_out = 32'hA000 + i;
                k = cyc;
                step;
                quiet;
                checks++;
                if ({bus.out_sd1_done, bus.out_sd0_done} !== (i == 0 ? 2'b01 : 2'b10)) begin
                    fails++; $display("FAIL cont_done r=%0d i=%0d: done1/done0=%b%b", r, i, bus.out_sd1_done, bus.out_sd0_done);
                end
            end
        end
    endtask

    task automatic test_overrun;
        int issued = 0;
        do_reset;
        pulse(1, 32'h20, 1'b1, 32'h0, 1'b0);
        step;
        pulse(1, 32'h24, 1'b1, 32'h0, 1'b0);
        step;
        quiet;
        checks++;
        if ({bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_overrun} !== {1'b1, 1'b1, 32'h20, 1'b1}) begin
            fails++; $display("FAIL ovr_issue: valid=%b grant=%b addr=%h overrun=%b expected 1 1 00000020 1",
                bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_overrun);
        end
        step;
        bus.in_sd_done = 1'b1;
        step;
        quiet;
        checks++;
        if (bus.out_sd1_done !== 1'b1) begin fails++; $display("FAIL ovr_done: done1=%b expected 1", bus.out_sd1_done); end
        for (int i = 0; i < 6; i++) begin
            issued += int'(bus.out_sd_in_valid);
            step;
        end
        checks++;
        if (issued != 0 || bus.out_overrun !== 1'b1) begin
            fails++; $display("FAIL ovr_discard: extra issues=%0d overrun=%b expected 0 1", issued, bus.out_overrun);
        end
    endtask

    task automatic test_spurious_done;
        logic [31:0] d0, d1;
        d0 = bus.out_sd0_data_out;
        d1 = bus.out_sd1_data_out;
        bus.in_sd_done = 1'b1;
        bus.in_sd_data_out = 32'hCAFE;
        step;
        quiet;
        checks++;
        if ({bus.out_sd0_done, bus.out_sd1_done, bus.out_busy, bus.out_sd_in_valid, bus.out_sd0_data_out, bus.out_sd1_data_out} !== {4'b0, d0, d1}) begin
            fails++; $display("FAIL spur_done: done0=%b done1=%b busy=%b data0=%h data1=%h expected 0 0 0 %h %h",
                bus.out_sd0_done, bus.out_sd1_done, bus.out_busy, bus.out_sd0_data_out, bus.out_sd1_data_out, d0, d1);
        end
        pulse(0, 32'h44, 1'b0, 32'h1, 1'b1);
        step;
        quiet;
        step;
        checks++;
        if ({bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_sd_wmask} !== {1'b1, 1'b0, 32'h44, 1'b1}) begin
            fails++; $display("FAIL spur_next: valid=%b grant=%b addr=%h wmask=%b expected 1 0 00000044 1",
                bus.out_sd_in_valid, bus.out_grant, bus.out_sd_addr, bus.out_sd_wmask);
        end
        step;
        bus.in_sd_done = 1'b1;
        step;
        quiet;
    endtask

    task automatic test_random;
        logic        pv [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        logic        pr [2];
        logic        pw [2];
        int          pc [2];
        logic [31:0] dout [2];
        logic [1:0]  exp_done;
        logic        last_m, infl, cur, ovr;
        int          iss_c, done_c;
        pv = '{1'b0, 1'b0};
        dout = '{32'h0, 32'h0};
        exp_done = 2'b00;
        last_m = 1'b1;
        infl = 1'b0;
        cur = 1'b0;
        ovr = 1'b0;
        iss_c = 0;
        done_c = -10;
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            logic e0, e1, exp_iv, exp_g, rw, wm;
            logic [31:0] a, d;
            e0 = pv[0] && pc[0] <= c - 2;
            e1 = pv[1] && pc[1] <= c - 2;
            exp_iv = !infl && c >= done_c + 2 && (e0 || e1);
            exp_g = (e0 && e1) ? !last_m : e1;
            checks++;
            if (bus.out_sd_in_valid !== exp_iv) begin
                fails++; $display("FAIL rnd_issue c=%0d: in_valid=%b expected %b", c, bus.out_sd_in_valid, exp_iv);
            end
            if (exp_iv) begin infl = 1'b1; cur = exp_g; iss_c = c; end
            if (infl) begin
                checks++;
                if ({bus.out_grant, bus.out_sd_addr, bus.out_sd_rw, bus.out_sd_data_in, bus.out_sd_wmask} !== {cur, pa[cur], pr[cur], pd[cur], pw[cur]}) begin
                    fails++; $display("FAIL rnd_fields c=%0d: grant=%b addr=%h rw=%b data=%h wm=%b expected %b %h %b %h %b", c,
                        bus.out_grant, bus.out_sd_addr, bus.out_sd_rw, bus.out_sd_data_in, bus.out_sd_wmask, cur, pa[cur], pr[cur], pd[cur], pw[cur]);
                end
            end
            checks++;
            if ({bus.out_busy, bus.out_overrun, bus.out_sd1_done, bus.out_sd0_done, bus.out_sd0_data_out, bus.out_sd1_data_out} !==
                {infl, ovr, exp_done, dout[0], dout[1]}) begin
                fails++; $display("FAIL rnd_status c=%0d: busy=%b ovr=%b done=%b%b d0=%h d1=%h expected %b %b %b %h %h", c,
                    bus.out_busy, bus.out_overrun, bus.out_sd1_done, bus.out_sd0_done, bus.out_sd0_data_out, bus.out_sd1_data_out,
                    infl, ovr, exp_done, dout[0], dout[1]);
            end
            exp_done = 2'b00;
            quiet;
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    a = $urandom;
                    d = $urandom;
                    rw = 1'($urandom_range(0, 1));
                    wm = 1'($urandom_range(0, 1));
                    pulse(n, a, rw, d, wm);
                    if (pv[n]) ovr = 1'b1;
                    else begin pv[n] = 1'b1; pa[n] = a; pd[n] = d; pr[n] = rw; pw[n] = wm; pc[n] = c; end
                end
            end
            bus.in_sd_done = $urandom_range(0, 3) == 0;
            bus.in_sd_data_out = $urandom;
            if (bus.in_sd_done && infl && c > iss_c) begin
                dout[cur] = bus.in_sd_data_out;
                exp_done[cur] = 1'b1;
                pv[cur] = 1'b0;
                last_m = cur;
                infl = 1'b0;
                done_c = c;
            end
            step;
        end
        quiet;
    endtask

    initial begin
        quiet;
        bus.in_sd0_addr = '0; bus.in_sd0_rw = 1'b0; bus.in_sd0_data_in = '0; bus.in_sd0_wmask = 1'b0;
        bus.in_sd1_addr = '0; bus.in_sd1_rw = 1'b0; bus.in_sd1_data_in = '0; bus.in_sd1_wmask = 1'b0;
        bus.in_sd_data_out = '0;
        test_reset;
        test_single_write;
        test_read_return;
        test_reset_mid_wait;
        test_contention;
        test_overrun;
        test_spurious_done;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
